// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter and branch resolution unit with vector flags and return stack
//
// Sequences the fetch address (PCNext) and resolves JMP/JEQ/JNE/JLT/CALL/RET/END
// against an R-lane flag register. Lane conditions reduce as any-lane or all-lanes.
// A DEPTH-entry return stack serves CALL/RET; misuse raises a sticky StackErr.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     run request (level); IDLE->RUN when 1, HALT->IDLE when 0
//   stall     freezes PC, flags, stack and state while in RUN
//   FlagsW    latch ALUFlags (also bypassed to the branch in the same cycle)
//   ALUFlags  per lane {LT, EQ}; lane i occupies bits [2i+1:2i]
//   LaneAll   0: any lane true, 1: all lanes true
//   Id        opcode field Instr[31:28]
//   Imm       absolute byte target, zero-extended to AW
//   PCNext    registered fetch address
//   EndFlag   program finished, held until the unit returns to IDLE
//   COMFlag   one-cycle flush pulse following a taken transfer
//   StackErr  sticky overflow/underflow indicator

module pc_branch_unit #(
  parameter int R     = 4,
  parameter int AW    = 32,
  parameter int IMMW  = 18,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            FlagsW,
  input  logic [2*R-1:0]  ALUFlags,
  input  logic            LaneAll,
  input  logic [3:0]      Id,
  input  logic [IMMW-1:0] Imm,
  output logic [AW-1:0]   PCNext,
  output logic            EndFlag,
  output logic            COMFlag,
  output logic            StackErr
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] OP_JNE  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JEQ  = 4'hD;
  localparam logic [3:0] OP_JLT  = 4'hE;
  localparam logic [3:0] OP_END  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*R-1:0] flag_reg;
  logic [SPW-1:0] sp, sp_next;
  logic [AW-1:0]  stack_mem [DEPTH];

  logic [AW-1:0]  pc_next;
  logic           end_next;
  logic           com_next;
  logic           err_next;
  logic           flag_we;
  logic           push_en;

  logic [2*R-1:0] flags_eff;
  logic [R-1:0]   eq_lanes;
  logic [R-1:0]   lt_lanes;
  logic           cond_eq;
  logic           cond_lt;

  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  imm_ext;
  logic           stack_full;
  logic           stack_empty;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;

  assign pc_inc      = PCNext + AW'(4);
  assign imm_ext     = AW'(Imm);
  assign stack_full  = (sp == SPW'(DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IW'(sp);
  assign top_idx     = IW'(sp - SPW'(1));

  // Same-cycle FlagsW bypasses the register so a flag-setting op and the
  // branch that consumes it can issue together.
  assign flags_eff = FlagsW ? ALUFlags : flag_reg;

  always_comb begin
    eq_lanes = '0;
    lt_lanes = '0;
    for (int i = 0; i < R; i++) begin
      eq_lanes[i] = flags_eff[2*i];
      lt_lanes[i] = flags_eff[2*i+1];
    end
  end

  assign cond_eq = LaneAll ? (&eq_lanes) : (|eq_lanes);
  assign cond_lt = LaneAll ? (&lt_lanes) : (|lt_lanes);

  always_comb begin
    state_next = state;
    pc_next    = PCNext;
    end_next   = EndFlag;
    com_next   = 1'b0;
    err_next   = StackErr;
    sp_next    = sp;
    flag_we    = 1'b0;
    push_en    = 1'b0;

    unique case (state)
      S_IDLE: begin
        pc_next  = '0;
        end_next = 1'b0;
        sp_next  = '0;
        if (start) begin
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        if (!stall) begin
          flag_we = FlagsW;
          pc_next = pc_inc;
          unique case (Id)
            OP_JMP: begin
              pc_next  = imm_ext;
              com_next = 1'b1;
            end
            OP_JEQ: begin
              if (cond_eq) begin
                pc_next  = imm_ext;
                com_next = 1'b1;
              end
            end
            OP_JNE: begin
              if (!cond_eq) begin
                pc_next  = imm_ext;
                com_next = 1'b1;
              end
            end
            OP_JLT: begin
              if (cond_lt) begin
                pc_next  = imm_ext;
                com_next = 1'b1;
              end
            end
            OP_CALL: begin
              // The jump is taken even when the push has to be dropped.
              pc_next  = imm_ext;
              com_next = 1'b1;
              if (stack_full) begin
                err_next = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_next = sp + SPW'(1);
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                err_next = 1'b1;
              end else begin
                pc_next  = stack_mem[top_idx];
                sp_next  = sp - SPW'(1);
                com_next = 1'b1;
              end
            end
            OP_END: begin
              pc_next    = PCNext;
              end_next   = 1'b1;
              state_next = S_HALT;
            end
            default: begin
            end
          endcase
        end
      end

      S_HALT: begin
        if (!start) begin
          state_next = S_IDLE;
          pc_next    = '0;
          end_next   = 1'b0;
          sp_next    = '0;
        end
      end

      default: begin
        state_next = S_IDLE;
        pc_next    = '0;
        end_next   = 1'b0;
        sp_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      PCNext   <= '0;
      EndFlag  <= 1'b0;
      COMFlag  <= 1'b0;
      StackErr <= 1'b0;
      flag_reg <= '0;
      sp       <= '0;
    end else begin
      state    <= state_next;
      PCNext   <= pc_next;
      EndFlag  <= end_next;
      COMFlag  <= com_next;
      StackErr <= err_next;
      sp       <= sp_next;
      if (flag_we) begin
        flag_reg <= ALUFlags;
      end
    end
  end

  // Entries above sp are never read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program-counter and branch-resolution unit for the RSA pipeline CPU, successor to the single-lane PC control unit. It sequences the fetch address and resolves JMP/JEQ/JLT plus the new JNE, CALL, RET and END opcodes against an R-lane vector flag register. Lane reduction is selectable (any-lane or all-lanes), a bounded return-address stack supports subroutines, and stall and restart handshakes are provided. It sits between the decode stage (Id/Imm) and instruction fetch (PCNext), and it drives the pipeline flush request.

## Interface
Parameters:
- R, 4, number of vector lanes contributing ALU flags
- AW, 32, PC width in bits; must be ≥ IMMW
- IMMW, 18, branch immediate width
- DEPTH, 4, return-stack entries (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request; level-sensitive
- stall  in  1  hold PC and all state this cycle (reset/start still honoured)
- FlagsW  in  1  write ALUFlags into flag register
- ALUFlags  in  R×2  per lane: bit0 = zero (EQ), bit1 = negative (LT)
- LaneAll  in  1  0 = condition true if any lane true; 1 = all lanes true
- Id  in  4  opcode field Instr[31:28]
- Imm  in  IMMW  absolute byte target, zero-extended to AW
- PCNext  out  AW  registered fetch address
- EndFlag  out  1  program finished (sticky until IDLE)
- COMFlag  out  1  one-cycle flush pulse after any taken transfer
- StackErr  out  1  sticky stack overflow/underflow

## Operation
- States: IDLE, RUN, HALT.
- IDLE: PCNext=0, stack pointer=0, EndFlag=0. When start=1, go to RUN; PCNext stays 0 for the first fetch.
- RUN, per non-stalled cycle, using the Id of that cycle:
  - 4'hC JMP: PC=Imm.
  - 4'hD JEQ: PC=Imm if EQ, else PC+4.
  - 4'h9 JNE: PC=Imm if not EQ, else PC+4.
  - 4'hE JLT: PC=Imm if LT, else PC+4.
  - 4'hA CALL: push PC+4, then PC=Imm.
  - 4'hB RET: pop into PC.
  - 4'hF END: EndFlag=1, PC held, go to HALT.
  - All other opcodes: PC+4.
- Condition: EQ = OR over lanes of bit0 (LaneAll=0) or AND over lanes (LaneAll=1). LT is reduced the same way from bit1.
- Flag source: if FlagsW=1 in the same cycle, the incoming ALUFlags are used (bypass) and also latched. Otherwise the latched register is used.
- Stack overflow: CALL with DEPTH entries already present sets StackErr. The push is dropped and the jump is still taken.
- Stack underflow: RET with the stack empty sets StackErr, and PC advances to PC+4.
- COMFlag=1 on the cycle after any taken JMP/JEQ/JNE/JLT/CALL/RET. It is 0 for not-taken branches, RET underflow and END.
- HALT: all outputs held. When start=0, go to IDLE.
- Arithmetic: PC+4 wraps modulo 2^AW. Imm is zero-extended with no shift.

## Timing
- Reset (async, reset=0): PCNext=0, EndFlag=0, COMFlag=0, StackErr=0, state IDLE, flag register=0, stack pointer=0.
- Latency: an Id/Imm presented in cycle n is reflected on PCNext after the rising edge ending cycle n. COMFlag aligns with that new PCNext.
- stall=1: PCNext, flags, stack and state are frozen, COMFlag=0, and FlagsW is ignored.
- Mid-RUN start=0 is ignored. Only END leaves RUN.
- Reset asserted mid-operation immediately forces the reset values, whatever the current state, stall or opcode.
- Simultaneous CALL with a full stack: target is taken, StackErr rises on the same edge.
- Simultaneous FlagsW and a conditional branch: the branch uses the new flags.

## Test plan
- Reset, start=1, Id=6 (mov) for 3 cycles → PCNext 0→4→8→C, COMFlag=0 throughout.
- JMP Imm=0x50 → PCNext=0x50 on the next edge, COMFlag=1 for exactly one cycle.
- R=4, FlagsW=1, ALUFlags lanes bit0={1,0,0,0}, JEQ Imm=0x13C. With LaneAll=0 → PCNext=0x13C. With LaneAll=1 → PCNext=PC+4 and COMFlag=0.
- Latch bit1 all-ones, then FlagsW=0 and JLT Imm=0x94 two cycles later → PCNext=0x94, taken from the latched register.
- DEPTH=4: five CALLs to 0x200 from PC=0x10 onward, then five RETs → StackErr=1 after the 5th CALL. The first four RETs return in LIFO order; the 5th RET gives PC+4 and StackErr stays 1.
- END, then stall/start toggles → EndFlag=1 and PCNext held. start=0 → IDLE with PCNext=0. Reset pulse mid-RUN → all outputs 0 asynchronously.
